// File: rtl/com_pkt_pkg.sv
// Shared constants and state encoding for the com packet receiver.
package com_pkt_pkg;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 12;
  localparam int TMO_DEF = 4095;

  localparam logic [7:0] HEAD0_DEF = 8'hEB;
  localparam logic [7:0] HEAD1_DEF = 8'h90;

  localparam logic [7:0] ST_IDLE = 8'b0000_0001;
  localparam logic [7:0] ST_WAIT = 8'b0000_0010;
  localparam logic [7:0] ST_H1   = 8'b0000_0100;
  localparam logic [7:0] ST_INF0 = 8'b0000_1000;
  localparam logic [7:0] ST_INF1 = 8'b0001_0000;
  localparam logic [7:0] ST_DATA = 8'b0010_0000;
  localparam logic [7:0] ST_CHK  = 8'b0100_0000;
  localparam logic [7:0] ST_DONE = 8'b1000_0000;

  typedef enum logic [7:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_H1   = ST_H1,
    S_INF0 = ST_INF0,
    S_INF1 = ST_INF1,
    S_DATA = ST_DATA,
    S_CHK  = ST_CHK,
    S_DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/com_pkt_tmo.sv
// Inter-byte idle counter: expires after CYC consecutive enabled,
// uncleared cycles.
module com_pkt_tmo #(
  parameter int CYC = 4095,
  parameter int W   = $clog2(CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || !en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign expire = en && !clr && (r_cnt == W'(CYC - 1));
endmodule

// File: rtl/com_pkt_rx.sv
// Framed byte-stream receiver: sync on HEAD0/HEAD1, parse info,
// write payload to RAM, verify XOR checksum.
module com_pkt_rx
  import com_pkt_pkg::*;
#(
  parameter logic [7:0] HEAD0   = HEAD0_DEF,
  parameter logic [7:0] HEAD1   = HEAD1_DEF,
  parameter int         TMO_CYC = TMO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  output logic              fd,
  input  logic [ADDR_W-1:0] ram_addr_init,
  input  logic [7:0]        com_rxd,
  input  logic              com_rxv,
  output logic [3:0]        btype,
  output logic [LEN_W-1:0]  dlen,
  output logic              chk_err,
  output logic [ADDR_W-1:0] ram_txa,
  output logic [7:0]        ram_txd,
  output logic              ram_txe
);
  state_t             r_state;
  logic [3:0]         r_btype;
  logic [LEN_W-1:0]   r_dlen;
  logic [LEN_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_acc;

  logic               w_tmo_en;
  logic               w_tmo;
  logic               w_abort;
  logic [LEN_W-1:0]   w_cnt_nx;

  assign w_tmo_en = (r_state == S_H1)   || (r_state == S_INF0) ||
                    (r_state == S_INF1) || (r_state == S_DATA) ||
                    (r_state == S_CHK);
  assign w_abort  = !fs && (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_cnt_nx = r_cnt + LEN_W'(1);

  com_pkt_tmo #(.CYC(TMO_CYC)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (com_rxv),
    .en     (w_tmo_en),
    .expire (w_tmo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_btype <= '0;
      r_dlen  <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_acc   <= '0;
      fd      <= 1'b0;
      btype   <= '0;
      dlen    <= '0;
      chk_err <= 1'b0;
      ram_txa <= '0;
      ram_txd <= '0;
      ram_txe <= 1'b0;
    end else begin
      ram_txe <= 1'b0;
      if (w_abort) begin
        r_state <= S_IDLE;
      end else if (w_tmo) begin
        r_state <= S_WAIT;
      end else begin
        unique case (r_state)
          S_IDLE: if (fs) begin
            r_addr  <= ram_addr_init;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: if (com_rxv && com_rxd == HEAD0) begin
            r_state <= S_H1;
          end
          S_H1: if (com_rxv) begin
            if (com_rxd == HEAD1)      r_state <= S_INF0;
            else if (com_rxd == HEAD0) r_state <= S_H1;
            else                       r_state <= S_WAIT;
          end
          S_INF0: if (com_rxv) begin
            r_btype       <= com_rxd[7:4];
            r_dlen[11:8]  <= com_rxd[3:0];
            r_acc         <= com_rxd;
            r_state       <= S_INF1;
          end
          S_INF1: if (com_rxv) begin
            r_dlen[7:0] <= com_rxd;
            r_acc       <= r_acc ^ com_rxd;
            if ({r_dlen[11:8], com_rxd} != '0) r_state <= S_DATA;
            else                               r_state <= S_CHK;
          end
          S_DATA: if (com_rxv) begin
            ram_txe <= 1'b1;
            ram_txd <= com_rxd;
            ram_txa <= r_addr;
            r_addr  <= r_addr + ADDR_W'(1);
            r_acc   <= r_acc ^ com_rxd;
            r_cnt   <= w_cnt_nx;
            if (w_cnt_nx == r_dlen) r_state <= S_CHK;
          end
          S_CHK: if (com_rxv) begin
            chk_err <= (com_rxd != r_acc);
            btype   <= r_btype;
            dlen    <= r_dlen;
            fd      <= 1'b1;
            r_state <= S_DONE;
          end
          S_DONE: if (!fs) begin
            fd      <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
